// File: rtl/logic_gate_pkg.sv
// Shared types and constants for the gate-bank self-test sequencer.
// Gate bit positions follow the gate bank's gate_out ordering.
package logic_gate_pkg;

  localparam int NUM_GATES = 8;
  localparam int NUM_VECS  = 4;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NAND = 2;
  localparam int GATE_NOTA = 3;
  localparam int GATE_NOTB = 4;
  localparam int GATE_NOR  = 5;
  localparam int GATE_XOR  = 6;
  localparam int GATE_XNOR = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

endpackage

// File: rtl/logic_gate_expect.sv
// Golden model of the 2-input gate bank: {a,b} -> expected gate outputs.
// Purely combinational; usable from the checker and from benches.
module logic_gate_expect
  import logic_gate_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] exp_o
);

  always_comb begin
    exp_o            = '0;
    exp_o[GATE_AND]  = a & b;
    exp_o[GATE_OR]   = a | b;
    exp_o[GATE_NAND] = ~(a & b);
    exp_o[GATE_NOTA] = ~a;
    exp_o[GATE_NOTB] = ~b;
    exp_o[GATE_NOR]  = ~(a | b);
    exp_o[GATE_XOR]  = a ^ b;
    exp_o[GATE_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/logic_gate_checker.sv
// Self-test sequencer: walks {a,b} through 00..11, settles, samples the
// gate bank and accumulates per-gate mismatches against the golden model.
module logic_gate_checker
  import logic_gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter bit FAIL_STOP     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 vec_a,
  output logic                 vec_b,
  input  logic [NUM_GATES-1:0] gate_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask,
  output logic [1:0]           first_fail_vec
);

  localparam int CW = (SETTLE_CYCLES > 0) ?
                      $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int LAST = (SETTLE_CYCLES > 0) ?
                        SETTLE_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = LAST[CW-1:0];
  localparam logic [1:0]    IDX_LAST = 2'(NUM_VECS - 1);

  state_t                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [1:0]             vec_q, vec_d;
  logic [NUM_GATES-1:0]   mask_q, mask_d;
  logic [1:0]             ffv_q, ffv_d;
  logic                   pass_q, pass_d;
  logic [NUM_GATES-1:0]   exp_v;
  logic [NUM_GATES-1:0]   mism;

  logic_gate_expect u_expect (
    .a     (idx_q[1]),
    .b     (idx_q[0]),
    .exp_o (exp_v)
  );

  assign mism = gate_out ^ exp_v;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_APPLY;
          idx_d   = '0;
          mask_d  = '0;
          ffv_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_APPLY: begin
        vec_d   = idx_q;
        cnt_d   = '0;
        state_d = (SETTLE_CYCLES == 0) ? S_CHECK : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
        mask_d = mask_q | mism;
        // first failure is the one seen while the mask is still clean
        if (mism != '0 && mask_q == '0) ffv_d = idx_q;
        if (idx_q == IDX_LAST || (FAIL_STOP && mism != '0)) begin
          state_d = S_DONE;
          pass_d  = (mask_d == '0);
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_APPLY;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      mask_q  <= '0;
      ffv_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_a          = vec_q[1];
  assign vec_b          = vec_q[0];
  assign busy           = (state_q == S_APPLY) ||
                          (state_q == S_WAIT)  ||
                          (state_q == S_CHECK);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign fail_mask      = mask_q;
  assign first_fail_vec = ffv_q;

endmodule
